// File: rtl/gray_ptr_sync_pkg.sv
// Shared FIFO package: synchronizer depth limits and Gray/binary conversions.
package gray_ptr_sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int PTR_MAX_W  = 32;

    // Operate on a zero-extended word; leading zeros leave the result unchanged.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(
        input logic [PTR_MAX_W-1:0] g
    );
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(
        input logic [PTR_MAX_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Gray pointer CDC synchronizer with binary conversion, advance tracking
// and sticky detection of illegal (backward or overrun) pointer steps.
module gray_ptr_sync
    import gray_ptr_sync_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   gray_in,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH:0]   gray_out,
    output logic [ADDR_WIDTH:0]   bin_out,
    output logic                  adv,
    output logic [ADDR_WIDTH:0]   delta,
    output logic                  err
);

    localparam int W = ADDR_WIDTH + 1;

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be within 2..4");
    end

    logic [STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]             bin_next;
    logic [W-1:0]             step;
    logic                     illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], gray_in};
        end
    end

    assign gray_out = sync_q[STAGES-1];

    always_comb begin
        bin_next = W'(gray2bin(PTR_MAX_W'(gray_out)));
        step     = bin_next - bin_out;
        // A full-depth step (only the wrap bit set) is still legal.
        illegal  = step[ADDR_WIDTH] && (|step[ADDR_WIDTH-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out <= '0;
            adv     <= 1'b0;
            delta   <= '0;
            err     <= 1'b0;
        end else begin
            bin_out <= bin_next;
            adv     <= (bin_next != bin_out);
            if (bin_next != bin_out) begin
                delta <= step;
            end
            if (illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync (ADDR_WIDTH=3) at STAGES=2 and STAGES=3.
module tb_gray_ptr_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       err_clr;
    logic [3:0] gray_out;
    logic [3:0] bin_out;
    logic       adv;
    logic [3:0] delta;
    logic       err;

    logic [3:0] g3_in;
    logic [3:0] g3_out;
    logic [3:0] b3_out;
    logic       adv3;
    logic [3:0] delta3;
    logic       err3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gray_ptr_sync #(.ADDR_WIDTH(3), .STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gray_in  (gray_in),
        .err_clr  (err_clr),
        .gray_out (gray_out),
        .bin_out  (bin_out),
        .adv      (adv),
        .delta    (delta),
        .err      (err)
    );

    gray_ptr_sync #(.ADDR_WIDTH(3), .STAGES(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .gray_in  (g3_in),
        .err_clr  (1'b0),
        .gray_out (g3_out),
        .bin_out  (b3_out),
        .adv      (adv3),
        .delta    (delta3),
        .err      (err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_out();
        return 32'({gray_out, bin_out, adv, delta, err});
    endfunction

    function automatic logic [31:0] all_out3();
        return 32'({g3_out, b3_out, adv3, delta3, err3});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        gray_in = 4'b0110;
        g3_in   = 4'b0110;
        err_clr = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("rst_hold", all_out(), 32'd0);
            chk("rst_hold3", all_out3(), 32'd0);
        end

        g3_in = 4'b0000;
        rst_n = 1'b1;
        tick(1);
        chk("rel_c1_gray", 32'(gray_out), 32'd0);
        chk("rel_c1_bin", 32'(bin_out), 32'd0);
        tick(1);
        chk("rel_c2_gray", 32'(gray_out), 32'd6);
        chk("rel_c2_bin", 32'(bin_out), 32'd0);
        tick(1);
        chk("rel_c3_bin", 32'(bin_out), 32'd4);
        chk("rel_c3_adv", 32'(adv), 32'd1);
        chk("rel_c3_delta", 32'(delta), 32'd4);
        chk("rel_c3_err", 32'(err), 32'd0);
        tick(1);
        chk("rel_c4_adv", 32'(adv), 32'd0);
        chk("rel_c4_delta", 32'(delta), 32'd4);

        rst_n   = 1'b0;
        gray_in = 4'b0000;
        #1;
        chk("async_rst", all_out(), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        gray_in = 4'b0001;
        tick(1);
        chk("s1_c1_gray", 32'(gray_out), 32'd0);
        tick(1);
        chk("s1_c2_gray", 32'(gray_out), 32'd1);
        chk("s1_c2_bin", 32'(bin_out), 32'd0);
        tick(1);
        chk("s1_c3_bin", 32'(bin_out), 32'd1);
        chk("s1_c3_adv", 32'(adv), 32'd1);
        chk("s1_c3_delta", 32'(delta), 32'd1);
        tick(1);
        chk("s1_c4_adv", 32'(adv), 32'd0);
        chk("s1_c4_delta", 32'(delta), 32'd1);

        gray_in = 4'b0110;
        tick(3);
        chk("j1to4_bin", 32'(bin_out), 32'd4);
        chk("j1to4_delta", 32'(delta), 32'd3);
        chk("j1to4_adv", 32'(adv), 32'd1);
        chk("j1to4_err", 32'(err), 32'd0);

        gray_in = 4'b1010;
        tick(3);
        chk("j4to12_bin", 32'(bin_out), 32'd12);
        chk("j4to12_delta", 32'(delta), 32'd8);
        chk("j4to12_err", 32'(err), 32'd0);

        gray_in = 4'b1000;
        tick(3);
        chk("j12to15_bin", 32'(bin_out), 32'd15);
        chk("j12to15_delta", 32'(delta), 32'd3);
        gray_in = 4'b0011;
        tick(3);
        chk("wrap_bin", 32'(bin_out), 32'd2);
        chk("wrap_delta", 32'(delta), 32'd3);
        chk("wrap_err", 32'(err), 32'd0);

        gray_in = 4'b0111;
        tick(3);
        chk("j2to5_bin", 32'(bin_out), 32'd5);
        gray_in = 4'b0010;
        tick(3);
        chk("back_bin", 32'(bin_out), 32'd3);
        chk("back_delta", 32'(delta), 32'd14);
        chk("back_err", 32'(err), 32'd1);

        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("err_sticky", 32'(err), 32'd1);
        end

        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 32'd0);

        gray_in = 4'b0001;
        tick(2);
        chk("pre_coinc_err", 32'(err), 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("coinc_delta", 32'(delta), 32'd14);
        chk("coinc_err", 32'(err), 32'd1);

        g3_in = 4'b0001;
        tick(2);
        chk("st3_c2_gray", 32'(g3_out), 32'd0);
        tick(1);
        chk("st3_c3_gray", 32'(g3_out), 32'd1);
        chk("st3_c3_bin", 32'(b3_out), 32'd0);
        tick(1);
        chk("st3_c4_bin", 32'(b3_out), 32'd1);
        chk("st3_c4_adv", 32'(adv3), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
